// File: rtl/snn_pkg.sv
// Shared definitions for the spiking-network datapath: widths, packet field
// positions and the result packet pack/unpack helpers.
package snn_pkg;

    localparam int WIDTH_DATA = 13;
    localparam int WIDTH_PKT  = 32;
    localparam int DEPTH_R    = 21;

    localparam int ROW_LSB  = 16;
    localparam int ROW_MSB  = 20;
    localparam int DATA_MSB = 12;
    localparam int ROW_W    = ROW_MSB - ROW_LSB + 1;

    // Result layout: {11'd0, row, 3'd0, data}
    function automatic logic [WIDTH_PKT-1:0] pack_result(input logic [ROW_W-1:0]      row,
                                                         input logic [WIDTH_DATA-1:0] data);
        logic [WIDTH_PKT-1:0] pkt;
        pkt = '0;
        pkt[ROW_MSB:ROW_LSB] = row;
        pkt[DATA_MSB:0]      = data;
        return pkt;
    endfunction

    function automatic logic [ROW_W-1:0] unpack_row(input logic [WIDTH_PKT-1:0] pkt);
        return pkt[ROW_MSB:ROW_LSB];
    endfunction

    function automatic logic [WIDTH_DATA-1:0] unpack_data(input logic [WIDTH_PKT-1:0] pkt);
        return pkt[DATA_MSB:0];
    endfunction

endpackage

// File: rtl/psum_lane_bank.sv
// Per-row accumulator, term counter and column counter with a single
// read-modify-write port. Build with PSUM_SAT_EN to clamp sums instead of wrapping.
module psum_lane_bank
    import snn_pkg::*;
#(
    parameter int NUM_TERMS = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic [ROW_W-1:0]      row,
    input  logic [WIDTH_DATA-1:0] psum,
    input  logic                  frame_clr,
    output logic                  last,
    output logic [WIDTH_DATA-1:0] sum,
    output logic                  col_full,
    output logic                  sat_ovf
);

    localparam int TERM_W = 5;
    localparam logic [TERM_W-1:0] LAST_TERM = TERM_W'(NUM_TERMS - 1);
    localparam logic [ROW_W-1:0]  LAST_COL  = ROW_W'(DEPTH_R - 1);

    logic [WIDTH_DATA-1:0] acc_q  [DEPTH_R];
    logic [TERM_W-1:0]     term_q [DEPTH_R];
    logic [ROW_W-1:0]      col_q  [DEPTH_R];

`ifdef PSUM_SAT_EN
    logic [WIDTH_DATA:0] wide;
`endif

    always_comb begin
        last     = (term_q[row] == LAST_TERM);
        col_full = (col_q[row] == LAST_COL);
`ifdef PSUM_SAT_EN
        wide    = {1'b0, acc_q[row]} + {1'b0, psum};
        sat_ovf = wide[WIDTH_DATA];
        sum     = wide[WIDTH_DATA] ? '1 : wide[WIDTH_DATA-1:0];
`else
        sat_ovf = 1'b0;
        sum     = acc_q[row] + psum;
`endif
    end

    // The row update is written after the frame clear so a same-cycle update wins for its row
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH_R; i++) begin
                acc_q[i]  <= '0;
                term_q[i] <= '0;
                col_q[i]  <= '0;
            end
        end else begin
            if (frame_clr) begin
                for (int i = 0; i < DEPTH_R; i++) begin
                    col_q[i] <= '0;
                end
            end
            if (en) begin
                if (last) begin
                    acc_q[row]  <= '0;
                    term_q[row] <= '0;
                    col_q[row]  <= col_full ? '0 : col_q[row] + ROW_W'(1);
                end else begin
                    acc_q[row]  <= sum;
                    term_q[row] <= term_q[row] + TERM_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/psum_accum.sv
// Partial-sum accumulator: sums NUM_TERMS contributions per output neuron and
// emits result packets with frame tracking. Optional macro: PSUM_SAT_EN.
module psum_accum
    import snn_pkg::*;
#(
    parameter int NUM_TERMS = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH_PKT-1:0] in_pkt,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [WIDTH_PKT-1:0] out_pkt,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 frame_done,
    output logic                 err
);

    localparam int FRAME_LEN = DEPTH_R * DEPTH_R;
    localparam int CNT_W     = $clog2(FRAME_LEN);
    localparam logic [CNT_W-1:0] LAST_OUT = CNT_W'(FRAME_LEN - 1);

    logic [ROW_W-1:0]      row;
    logic [ROW_W-1:0]      lane_row;
    logic [WIDTH_DATA-1:0] psum;
    logic                  row_ok;
    logic                  accept;
    logic                  handoff;
    logic                  upd;
    logic                  complete;
    logic                  frame_end;
    logic                  lane_err;
    logic                  last;
    logic                  col_full;
    logic                  sat_ovf;
    logic [WIDTH_DATA-1:0] sum;
    logic [CNT_W-1:0]      out_cnt;
    logic                  unused_pkt_bits;

    assign row             = in_pkt[ROW_MSB:ROW_LSB];
    assign psum            = in_pkt[DATA_MSB:0];
    assign unused_pkt_bits = ^{in_pkt[WIDTH_PKT-1:ROW_MSB+1], in_pkt[ROW_LSB-1:DATA_MSB+1]};

    assign in_ready  = !out_valid || out_ready;
    assign accept    = in_valid && in_ready;
    assign handoff   = out_valid && out_ready;
    assign row_ok    = (row < ROW_W'(DEPTH_R));
    assign lane_row  = row_ok ? row : '0;
    assign upd       = accept && row_ok;
    assign complete  = upd && last;
    assign frame_end = handoff && (out_cnt == LAST_OUT);
    assign lane_err  = upd && (sat_ovf || (last && col_full));

    psum_lane_bank #(
        .NUM_TERMS (NUM_TERMS)
    ) u_bank (
        .clk       (clk),
        .reset     (reset),
        .en        (upd),
        .row       (lane_row),
        .psum      (psum),
        .frame_clr (frame_end),
        .last      (last),
        .sum       (sum),
        .col_full  (col_full),
        .sat_ovf   (sat_ovf)
    );

    // A new result overwrites the register in the same cycle as a hand-off, so no bubble
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid  <= 1'b0;
            out_pkt    <= '0;
            frame_done <= 1'b0;
            err        <= 1'b0;
            out_cnt    <= '0;
        end else begin
            if (complete) begin
                out_pkt   <= pack_result(row, sum);
                out_valid <= 1'b1;
            end else if (handoff) begin
                out_valid <= 1'b0;
            end
            if (handoff) begin
                out_cnt <= frame_end ? '0 : out_cnt + CNT_W'(1);
            end
            frame_done <= frame_end;
            if ((accept && !row_ok) || lane_err) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_psum_accum.sv
// Self-checking bench for psum_accum: directed cases with literal results plus
// two random full frames, all compared every cycle against a behavioural model.
module tb_psum_accum;

    localparam int NT   = 3;
    localparam int D    = 21;
    localparam int MAXV = 8191;

    logic        clk       = 1'b0;
    logic        reset     = 1'b1;
    logic [31:0] in_pkt    = '0;
    logic        in_valid  = 1'b0;
    logic        out_ready = 1'b1;
    logic        in_ready;
    logic [31:0] out_pkt;
    logic        out_valid;
    logic        frame_done;
    logic        err;

    int vectors     = 0;
    int miscompares = 0;
    bit chk_en      = 1'b0;
    bit rdy_rand    = 1'b0;
    int fd_cnt      = 0;
    int ho_cnt      = 0;

    int          m_acc  [D];
    int          m_term [D];
    int          m_col  [D];
    int          m_out_cnt;
    bit          m_valid;
    bit          m_fd;
    bit          m_err;
    logic [31:0] m_pkt;

    always #5 clk = ~clk;

    psum_accum #(
        .NUM_TERMS (NT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_pkt     (in_pkt),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_pkt    (out_pkt),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .frame_done (frame_done),
        .err        (err)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: per-row sums and counters kept as plain integers
    always @(posedge clk) begin
        int r;
        int p;
        int total;
        int old_col;
        bit acc;
        bit hand;
        bit fe;
        if (reset) begin
            for (int i = 0; i < D; i++) begin
                m_acc[i]  = 0;
                m_term[i] = 0;
                m_col[i]  = 0;
            end
            m_valid   = 1'b0;
            m_pkt     = '0;
            m_fd      = 1'b0;
            m_err     = 1'b0;
            m_out_cnt = 0;
        end else begin
            acc  = in_valid && (!m_valid || out_ready);
            hand = m_valid && out_ready;
            fe   = hand && (m_out_cnt == D * D - 1);
            r    = int'(in_pkt[20:16]);
            p    = int'(in_pkt[12:0]);
            old_col = (r < D) ? m_col[r] : 0;
            m_fd = fe;
            if (hand) begin
                m_out_cnt = fe ? 0 : m_out_cnt + 1;
                m_valid   = 1'b0;
            end
            if (fe) begin
                for (int i = 0; i < D; i++) m_col[i] = 0;
            end
            if (acc) begin
                if (r >= D) begin
                    m_err = 1'b1;
                end else begin
                    total = m_acc[r] + p;
                    if (total > MAXV) begin
`ifdef PSUM_SAT_EN
                        total = MAXV;
                        m_err = 1'b1;
`else
                        total = total % (MAXV + 1);
`endif
                    end
                    if (m_term[r] == NT - 1) begin
                        m_pkt     = 32'(r * 65536 + total);
                        m_valid   = 1'b1;
                        m_acc[r]  = 0;
                        m_term[r] = 0;
                        if (old_col == D - 1) begin
                            m_err    = 1'b1;
                            m_col[r] = 0;
                        end else begin
                            m_col[r] = old_col + 1;
                        end
                    end else begin
                        m_acc[r] = total;
                        m_term[r]++;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            checkOutput("in_ready", 32'(in_ready), 32'(!m_valid || out_ready));
            checkOutput("out_valid", 32'(out_valid), 32'(m_valid));
            checkOutput("out_pkt", out_pkt, m_pkt);
            checkOutput("frame_done", 32'(frame_done), 32'(m_fd));
            checkOutput("err", 32'(err), 32'(m_err));
            if (frame_done) fd_cnt++;
            if (out_valid && out_ready) ho_cnt++;
        end
    end

    always @(posedge clk) begin
        #1;
        if (rdy_rand) out_ready = ($urandom_range(3) != 0);
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [31:0] mk(input int row, input int psum);
        return 32'(row * 65536 + psum);
    endfunction

    // Holds the packet until the edge that accepts it, then deasserts in_valid
    task automatic applyStimulus(input logic [31:0] pkt);
        int n;
        n        = 0;
        in_pkt   = pkt;
        in_valid = 1'b1;
        while (!in_ready && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) checkOutput("accept_timeout", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        int rem [D];
        int r;
        int n;
        logic [31:0] junk;

        tick();
        tick();
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_out_pkt", out_pkt, 32'd0);
        checkOutput("rst_frame_done", 32'(frame_done), 32'd0);
        checkOutput("rst_err", 32'(err), 32'd0);
        reset  = 1'b0;
        chk_en = 1'b1;

        applyStimulus(mk(5, 10));
        applyStimulus(mk(5, 20));
        applyStimulus(mk(5, 30));
        checkOutput("row5_valid", 32'(out_valid), 32'd1);
        checkOutput("row5_pkt", out_pkt, 32'h0005_003C);
        tick();
        checkOutput("row5_valid_drop", 32'(out_valid), 32'd0);

        applyStimulus(mk(2, 1));
        applyStimulus(mk(7, 100));
        applyStimulus(mk(2, 2));
        applyStimulus(mk(7, 200));
        applyStimulus(mk(2, 3));
        checkOutput("row2_pkt", out_pkt, 32'h0002_0006);
        applyStimulus(mk(7, 300));
        checkOutput("row7_pkt", out_pkt, 32'h0007_0258);
        tick();

        out_ready = 1'b0;
        applyStimulus(mk(1, 1));
        applyStimulus(mk(1, 1));
        applyStimulus(mk(1, 1));
        for (int i = 0; i < 5; i++) begin
            checkOutput("hold_in_ready", 32'(in_ready), 32'd0);
            checkOutput("hold_valid", 32'(out_valid), 32'd1);
            checkOutput("hold_pkt", out_pkt, 32'h0001_0003);
            tick();
        end
        out_ready = 1'b1;
        #1;
        checkOutput("release_in_ready", 32'(in_ready), 32'd1);
        tick();
        checkOutput("release_valid", 32'(out_valid), 32'd0);

        applyStimulus(mk(3, 8000));
        applyStimulus(mk(3, 100));
        applyStimulus(mk(3, 50));
        checkOutput("row3_pkt", out_pkt, 32'h0003_1FD6);
        applyStimulus(mk(4, 8000));
        applyStimulus(mk(4, 200));
        applyStimulus(mk(4, 0));
`ifdef PSUM_SAT_EN
        checkOutput("row4_pkt", out_pkt, 32'h0004_1FFF);
        checkOutput("row4_err", 32'(err), 32'd1);
`else
        checkOutput("row4_pkt", out_pkt, 32'h0004_0008);
        checkOutput("row4_err", 32'(err), 32'd0);
`endif

        applyStimulus(mk(22, 5));
        checkOutput("bad_row_valid", 32'(out_valid), 32'd0);
        checkOutput("bad_row_err", 32'(err), 32'd1);
        tick();
        checkOutput("bad_row_no_out", 32'(out_valid), 32'd0);

        applyStimulus(mk(0, 9));
        applyStimulus(mk(6, 1));
        applyStimulus(mk(6, 1));
        applyStimulus(mk(6, 1));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkOutput("midrst_valid", 32'(out_valid), 32'd0);
        checkOutput("midrst_err", 32'(err), 32'd0);
        applyStimulus(mk(0, 5));
        applyStimulus(mk(0, 6));
        applyStimulus(mk(0, 7));
        checkOutput("row0_pkt", out_pkt, 32'h0000_0012);
        tick();

        reset = 1'b1;
        tick();
        reset    = 1'b0;
        fd_cnt   = 0;
        ho_cnt   = 0;
        rdy_rand = 1'b1;
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < D; i++) rem[i] = D * NT;
            for (int k = 0; k < D * D * NT; k++) begin
                r = int'($urandom_range(D - 1));
                while (rem[r] == 0) r = int'($urandom_range(D - 1));
                rem[r]--;
                junk = $urandom & 32'hFFE0_E000;
                applyStimulus(mk(r, int'($urandom_range(MAXV))) | junk);
                if ($urandom_range(7) == 0) tick();
            end
        end
        n = 0;
        while (out_valid && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) checkOutput("drain_timeout", 32'(out_valid), 32'd0);
        rdy_rand  = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        checkOutput("frame_done_count", 32'(fd_cnt), 32'd2);
        checkOutput("handoff_count", 32'(ho_cnt), 32'(2 * D * D));

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
